// File: rtl/bcd_arb_pkg.sv
// Shared constants, FSM state encoding and result payload for the bcd_32 arbiter.
package bcd_arb_pkg;

  localparam int unsigned BIN_W       = 32;
  localparam int unsigned BCD_W       = 40;
  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 64;

  localparam logic [BCD_W-1:0] BCD_ERR = {BCD_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_SEND,
    ST_WAIT,
    ST_RETURN
  } state_e;

  typedef struct packed {
    logic             err;
    logic [BCD_W-1:0] data;
  } result_t;

endpackage

// File: rtl/bcd_arb_rr.sv
// Round-robin selector: first asserted request at or above the pointer, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant_c,
  output logic             o_any_c
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant_c = '0;
    o_any_c   = |i_req;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IDX_W'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found   = 1'b1;
        o_grant_c = w_idx;
      end
    end
  end

endmodule

// File: rtl/bcd_arb.sv
// Shares one bcd_32 converter among N_REQ requesters, one conversion in flight,
// with round-robin grant and a bounded wait for the converter result.
module bcd_arb
  import bcd_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [BIN_W*N_REQ-1:0] req_bin_data_i,
  input  logic [N_REQ-1:0]       req_bin_data_valid_i,
  output logic [N_REQ-1:0]       req_bin_redy_o,
  output logic [BCD_W-1:0]       req_bcd_data_o,
  output logic [N_REQ-1:0]       req_bcd_data_valid_o,
  input  logic [N_REQ-1:0]       req_bcd_redy_i,
  output logic                   req_err_o,
  output logic [BIN_W-1:0]       cnv_bin_data_o,
  output logic                   cnv_bin_data_valid_o,
  input  logic                   cnv_bin_redy_i,
  input  logic [BCD_W-1:0]       cnv_bcd_data_i,
  input  logic                   cnv_bcd_data_valid_i,
  output logic                   cnv_bcd_redy_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_e           r_state, w_nxt_state;
  logic [IDX_W-1:0] r_grant, w_nxt_grant;
  logic [IDX_W-1:0] r_rr_ptr, w_nxt_rr_ptr;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [BIN_W-1:0] r_operand, w_nxt_operand;
  result_t          r_result, w_nxt_result;
  logic [N_REQ-1:0] r_bin_redy, w_nxt_bin_redy;
  logic [N_REQ-1:0] r_bcd_valid, w_nxt_bcd_valid;
  logic             r_cnv_bin_valid, w_nxt_cnv_bin_valid;
  logic             r_cnv_bcd_redy, w_nxt_cnv_bcd_redy;

  logic [IDX_W-1:0] w_arb_grant;
  logic             w_arb_any;
  logic [N_REQ-1:0] w_arb_oh;
  logic [N_REQ-1:0] w_grant_oh;
  logic [BIN_W-1:0] w_req_ops [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_ops
    assign w_req_ops[k] = req_bin_data_i[k*BIN_W +: BIN_W];
  end

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req     (req_bin_data_valid_i),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_arb_grant),
    .o_any_c   (w_arb_any)
  );

  assign w_arb_oh   = ONE_HOT0 << w_arb_grant;
  assign w_grant_oh = ONE_HOT0 << r_grant;

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    w_nxt_state         = r_state;
    w_nxt_grant         = r_grant;
    w_nxt_rr_ptr        = r_rr_ptr;
    w_nxt_cnt           = r_cnt;
    w_nxt_operand       = r_operand;
    w_nxt_result        = r_result;
    w_nxt_bin_redy      = '0;
    w_nxt_bcd_valid     = '0;
    w_nxt_cnv_bin_valid = 1'b0;
    w_nxt_cnv_bcd_redy  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_any) begin
          w_nxt_state    = ST_ACCEPT;
          w_nxt_grant    = w_arb_grant;
          w_nxt_rr_ptr   = (w_arb_grant == IDX_W'(N_REQ - 1)) ? '0 : w_arb_grant + IDX_W'(1);
          w_nxt_bin_redy = w_arb_oh;
        end
      end
      ST_ACCEPT: begin
        w_nxt_operand       = w_req_ops[r_grant];
        w_nxt_state         = ST_SEND;
        w_nxt_cnv_bin_valid = 1'b1;
      end
      ST_SEND: begin
        w_nxt_cnv_bin_valid = 1'b1;
        if (cnv_bin_redy_i) begin
          w_nxt_state         = ST_WAIT;
          w_nxt_cnv_bin_valid = 1'b0;
          w_nxt_cnv_bcd_redy  = 1'b1;
          w_nxt_cnt           = '0;
          w_nxt_operand       = '0;
        end
      end
      ST_WAIT: begin
        w_nxt_cnv_bcd_redy = 1'b1;
        w_nxt_cnt          = r_cnt + CNT_W'(1);
        // A result arriving on the timeout cycle takes priority over the error.
        if (cnv_bcd_data_valid_i) begin
          w_nxt_state        = ST_RETURN;
          w_nxt_result       = '{err: 1'b0, data: cnv_bcd_data_i};
          w_nxt_cnv_bcd_redy = 1'b0;
          w_nxt_bcd_valid    = w_grant_oh;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_nxt_state        = ST_RETURN;
          w_nxt_result       = '{err: 1'b1, data: BCD_ERR};
          w_nxt_cnv_bcd_redy = 1'b0;
          w_nxt_bcd_valid    = w_grant_oh;
        end
      end
      ST_RETURN: begin
        w_nxt_bcd_valid = w_grant_oh;
        if (req_bcd_redy_i[r_grant]) begin
          w_nxt_state     = ST_IDLE;
          w_nxt_bcd_valid = '0;
          w_nxt_result    = '0;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_grant         <= '0;
      r_rr_ptr        <= '0;
      r_cnt           <= '0;
      r_operand       <= '0;
      r_result        <= '0;
      r_bin_redy      <= '0;
      r_bcd_valid     <= '0;
      r_cnv_bin_valid <= 1'b0;
      r_cnv_bcd_redy  <= 1'b0;
    end else begin
      r_state         <= w_nxt_state;
      r_grant         <= w_nxt_grant;
      r_rr_ptr        <= w_nxt_rr_ptr;
      r_cnt           <= w_nxt_cnt;
      r_operand       <= w_nxt_operand;
      r_result        <= w_nxt_result;
      r_bin_redy      <= w_nxt_bin_redy;
      r_bcd_valid     <= w_nxt_bcd_valid;
      r_cnv_bin_valid <= w_nxt_cnv_bin_valid;
      r_cnv_bcd_redy  <= w_nxt_cnv_bcd_redy;
    end
  end

  assign req_bin_redy_o       = r_bin_redy;
  assign req_bcd_data_o       = r_result.data;
  assign req_bcd_data_valid_o = r_bcd_valid;
  assign req_err_o            = r_result.err;
  assign cnv_bin_data_o       = r_operand;
  assign cnv_bin_data_valid_o = r_cnv_bin_valid;
  assign cnv_bcd_redy_o       = r_cnv_bcd_redy;

endmodule

// File: tb/tb_bcd_arb.sv
// Directed bench for bcd_arb: requesters and the converter are driven by tasks,
// expected values are hand-derived constants.
module tb_bcd_arb;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [127:0] req_bin_data_i = '0;
  logic [3:0]   req_bin_data_valid_i = '0;
  logic [3:0]   req_bin_redy_o;
  logic [39:0]  req_bcd_data_o;
  logic [3:0]   req_bcd_data_valid_o;
  logic [3:0]   req_bcd_redy_i = '0;
  logic         req_err_o;
  logic [31:0]  cnv_bin_data_o;
  logic         cnv_bin_data_valid_o;
  logic         cnv_bin_redy_i = 1'b0;
  logic [39:0]  cnv_bcd_data_i = '0;
  logic         cnv_bcd_data_valid_i = 1'b0;
  logic         cnv_bcd_redy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bcd_arb #(.N_REQ(4), .TIMEOUT(64)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .req_bin_data_i       (req_bin_data_i),
    .req_bin_data_valid_i (req_bin_data_valid_i),
    .req_bin_redy_o       (req_bin_redy_o),
    .req_bcd_data_o       (req_bcd_data_o),
    .req_bcd_data_valid_o (req_bcd_data_valid_o),
    .req_bcd_redy_i       (req_bcd_redy_i),
    .req_err_o            (req_err_o),
    .cnv_bin_data_o       (cnv_bin_data_o),
    .cnv_bin_data_valid_o (cnv_bin_data_valid_o),
    .cnv_bin_redy_i       (cnv_bin_redy_i),
    .cnv_bcd_data_i       (cnv_bcd_data_i),
    .cnv_bcd_data_valid_i (cnv_bcd_data_valid_i),
    .cnv_bcd_redy_o       (cnv_bcd_redy_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Behaviour of the external bcd_32 converter.
  function automatic logic [39:0] bin2bcd(input logic [31:0] b);
    logic [39:0]     r;
    longint unsigned v;
    r = '0;
    v = longint'(b);
    for (int i = 0; i < 10; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic set_req(input int p, input logic [31:0] d);
    req_bin_data_i[p*32 +: 32] = d;
    req_bin_data_valid_i[p]    = 1'b1;
  endtask

  // One full transaction: grant, operand to converter, optional response, result, optional ack.
  task automatic serve_one(input int lat, input bit respond, input bit ack,
                           output int port, output int wait_cyc, output logic [3:0] vld,
                           output logic [39:0] data, output logic err, output bit to);
    int          n;
    logic [31:0] op;
    to = 0; port = -1; wait_cyc = 0; vld = '0; data = '0; err = 1'b0;
    n = 0;
    while (req_bin_redy_o == 4'b0 && n < 20) begin tick(); n++; end
    if (req_bin_redy_o == 4'b0) begin to = 1; return; end
    for (int k = 0; k < 4; k++) if (req_bin_redy_o[k]) port = k;
    tick();
    req_bin_data_valid_i[port] = 1'b0;
    n = 0;
    while (!cnv_bin_data_valid_o && n < 20) begin tick(); n++; end
    if (!cnv_bin_data_valid_o) begin to = 1; return; end
    op = cnv_bin_data_o;
    cnv_bin_redy_i = 1'b1;
    tick();
    cnv_bin_redy_i = 1'b0;
    if (respond) begin
      repeat (lat) begin tick(); wait_cyc++; end
      cnv_bcd_data_i       = bin2bcd(op);
      cnv_bcd_data_valid_i = 1'b1;
      tick(); wait_cyc++;
      cnv_bcd_data_valid_i = 1'b0;
      cnv_bcd_data_i       = '0;
    end
    while (req_bcd_data_valid_o == 4'b0 && wait_cyc < 200) begin tick(); wait_cyc++; end
    if (req_bcd_data_valid_o == 4'b0) begin to = 1; return; end
    vld = req_bcd_data_valid_o; data = req_bcd_data_o; err = req_err_o;
    if (ack) begin
      req_bcd_redy_i = vld;
      tick();
      req_bcd_redy_i = '0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    checks++;
    if ({req_bin_redy_o, req_bcd_data_valid_o, req_err_o, cnv_bin_data_valid_o, cnv_bcd_redy_o} !== 11'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 0", {req_bin_redy_o, req_bcd_data_valid_o, req_err_o, cnv_bin_data_valid_o, cnv_bcd_redy_o});
    end
    checks++;
    if (req_bcd_data_o !== 40'h0) begin errors++; $display("FAIL reset_bcd_data: got %h exp 0", req_bcd_data_o); end
    checks++;
    if (cnv_bin_data_o !== 32'h0) begin errors++; $display("FAIL reset_cnv_data: got %h exp 0", cnv_bin_data_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int p, w; logic [3:0] v; logic [39:0] d; logic e; bit to;
    set_req(0, 32'd1234);
    serve_one(5, 1, 1, p, w, v, d, e, to);
    checks++; if (to)           begin errors++; $display("FAIL single_timeout: handshake stalled"); end
    checks++; if (v !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b exp 0001", v); end
    checks++; if (d !== 40'h00_0000_1234) begin errors++; $display("FAIL single_data: got %h exp 0000001234", d); end
    checks++; if (e !== 1'b0)    begin errors++; $display("FAIL single_err: got %b exp 0", e); end
    checks++; if (w != 6)        begin errors++; $display("FAIL single_latency: got %0d exp 6", w); end
    checks++;
    if (req_bcd_data_valid_o !== 4'b0 || req_bcd_data_o !== 40'h0) begin
      errors++; $display("FAIL single_idle: valid %b data %h exp 0/0", req_bcd_data_valid_o, req_bcd_data_o);
    end
  endtask

  task automatic test_round_robin();
    int p, w; logic [3:0] v; logic [39:0] d; logic e; bit to;
    int exp_order [7] = '{0, 1, 2, 3, 0, 1, 2};
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int k = 0; k < 4; k++) set_req(k, 32'(10 * (k + 1)));
    for (int i = 0; i < 7; i++) begin
      serve_one(2, 1, 1, p, w, v, d, e, to);
      checks++;
      if (to || p != exp_order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got port %0d exp %0d", i, p, exp_order[i]);
      end
      checks++;
      if (v !== (4'b0001 << exp_order[i])) begin
        errors++; $display("FAIL rr_valid[%0d]: got %b exp %b", i, v, 4'b0001 << exp_order[i]);
      end
      checks++;
      if (d !== 40'(16 * (exp_order[i] + 1))) begin
        errors++; $display("FAIL rr_data[%0d]: got %h exp %h", i, d, 40'(16 * (exp_order[i] + 1)));
      end
      if (i == 2) for (int k = 0; k < 3; k++) req_bin_data_valid_i[k] = 1'b1;
    end
  endtask

  task automatic test_max();
    int p, w; logic [3:0] v; logic [39:0] d; logic e; bit to;
    set_req(3, 32'hFFFF_FFFF);
    serve_one(3, 1, 1, p, w, v, d, e, to);
    checks++; if (to || v !== 4'b1000) begin errors++; $display("FAIL max_valid: got %b exp 1000", v); end
    checks++; if (d !== 40'h42_9496_7295) begin errors++; $display("FAIL max_data: got %h exp 4294967295", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL max_err: got %b exp 0", e); end
  endtask

  task automatic test_timeout();
    int p, w; logic [3:0] v; logic [39:0] d; logic e; bit to;
    set_req(1, 32'd7);
    serve_one(0, 0, 1, p, w, v, d, e, to);
    checks++; if (to || v !== 4'b0010) begin errors++; $display("FAIL tmo_valid: got %b exp 0010", v); end
    checks++; if (w != 64) begin errors++; $display("FAIL tmo_cycles: got %0d exp 64", w); end
    checks++; if (d !== 40'hFF_FFFF_FFFF) begin errors++; $display("FAIL tmo_data: got %h exp ffffffffff", d); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b exp 1", e); end
    set_req(2, 32'd99);
    serve_one(63, 1, 1, p, w, v, d, e, to);
    checks++; if (to || v !== 4'b0100) begin errors++; $display("FAIL race_valid: got %b exp 0100", v); end
    checks++; if (w != 64) begin errors++; $display("FAIL race_cycles: got %0d exp 64", w); end
    checks++; if (d !== 40'h00_0000_0099) begin errors++; $display("FAIL race_data: got %h exp 0000000099", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL race_err: got %b exp 0", e); end
  endtask

  task automatic test_back_to_back_hold();
    int p, w; logic [3:0] v; logic [39:0] d; logic e; bit to;
    set_req(0, 32'd5);
    serve_one(1, 1, 0, p, w, v, d, e, to);
    checks++; if (to || v !== 4'b0001) begin errors++; $display("FAIL hold_first: got %b exp 0001", v); end
    set_req(1, 32'd6);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (req_bcd_data_valid_o !== 4'b0001 || req_bcd_data_o !== 40'h5 || req_err_o !== 1'b0 || req_bin_redy_o !== 4'b0) begin
        errors++; $display("FAIL hold_stable[%0d]: valid %b data %h err %b redy %b exp 0001/5/0/0000",
                           i, req_bcd_data_valid_o, req_bcd_data_o, req_err_o, req_bin_redy_o);
      end
    end
    req_bcd_redy_i[0] = 1'b1;
    tick();
    req_bcd_redy_i[0] = 1'b0;
    checks++;
    if (req_bcd_data_valid_o !== 4'b0 || req_bcd_data_o !== 40'h0 || req_bin_redy_o !== 4'b0) begin
      errors++; $display("FAIL hold_release: valid %b data %h redy %b exp 0/0/0", req_bcd_data_valid_o, req_bcd_data_o, req_bin_redy_o);
    end
    serve_one(1, 1, 1, p, w, v, d, e, to);
    checks++; if (to || p != 1 || d !== 40'h6) begin errors++; $display("FAIL hold_next: got port %0d data %h exp 1/6", p, d); end
  endtask

  task automatic test_reset_wait();
    int p, w, n; logic [3:0] v; logic [39:0] d; logic e; bit to;
    set_req(1, 32'd77);
    n = 0;
    while (req_bin_redy_o == 4'b0 && n < 20) begin tick(); n++; end
    checks++; if (req_bin_redy_o !== 4'b0010) begin errors++; $display("FAIL rw_grant: got %b exp 0010", req_bin_redy_o); end
    tick();
    req_bin_data_valid_i[1] = 1'b0;
    n = 0;
    while (!cnv_bin_data_valid_o && n < 20) begin tick(); n++; end
    checks++; if (cnv_bin_data_o !== 32'd77) begin errors++; $display("FAIL rw_operand: got %0d exp 77", cnv_bin_data_o); end
    cnv_bin_redy_i = 1'b1;
    tick();
    cnv_bin_redy_i = 1'b0;
    checks++; if (cnv_bcd_redy_o !== 1'b1) begin errors++; $display("FAIL rw_wait: got %b exp 1", cnv_bcd_redy_o); end
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if ({req_bin_redy_o, req_bcd_data_valid_o, req_err_o, cnv_bin_data_valid_o, cnv_bcd_redy_o} !== 11'b0 ||
        req_bcd_data_o !== 40'h0 || cnv_bin_data_o !== 32'h0) begin
      errors++; $display("FAIL rw_reset_outs: ctrl %b data %h op %h exp 0",
                         {req_bin_redy_o, req_bcd_data_valid_o, req_err_o, cnv_bin_data_valid_o, cnv_bcd_redy_o},
                         req_bcd_data_o, cnv_bin_data_o);
    end
    cnv_bcd_data_i       = bin2bcd(32'd77);
    cnv_bcd_data_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (req_bcd_data_valid_o !== 4'b0 || req_bcd_data_o !== 40'h0) begin
        errors++; $display("FAIL rw_late[%0d]: valid %b data %h exp 0/0", i, req_bcd_data_valid_o, req_bcd_data_o);
      end
    end
    cnv_bcd_data_valid_i = 1'b0;
    cnv_bcd_data_i       = '0;
    set_req(0, 32'd1);
    set_req(2, 32'd3);
    serve_one(1, 1, 1, p, w, v, d, e, to);
    checks++; if (to || p != 0 || d !== 40'h1) begin errors++; $display("FAIL rw_ptr: got port %0d data %h exp 0/1", p, d); end
    serve_one(1, 1, 1, p, w, v, d, e, to);
    checks++; if (to || p != 2 || d !== 40'h3) begin errors++; $display("FAIL rw_next: got port %0d data %h exp 2/3", p, d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max();
    test_timeout();
    test_back_to_back_hold();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
